// File: rtl/id_ex_stage_pkg.sv
// Shared types and encodings for the ID->EX pipeline slice.
package id_ex_stage_pkg;

  localparam int REG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  // Only the bits that must be cleared on flush live here; ALUOp/funct3 ride with data.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       auipc;
    logic       alu_db_src;
    logic [1:0] result_src;
    logic       reg_ren;
    logic       rs2_used;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_load_use.sv
// Combinational load-use detect: a load in EX feeding a source register of the instruction in ID.
module hazard_load_use
  import id_ex_stage_pkg::*;
(
  input  logic             valid_e_i,
  input  logic             memread_e_i,
  input  logic             regwrite_e_i,
  input  logic [REG_W-1:0] rd_e_i,
  input  logic             valid_d_i,
  input  logic             reg_ren_d_i,
  input  logic             rs2_used_d_i,
  input  logic [REG_W-1:0] rs1_d_i,
  input  logic [REG_W-1:0] rs2_d_i,
  output logic             load_use_o
);

  logic load_in_ex;
  logic src_match;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_in_ex = valid_e_i && memread_e_i && regwrite_e_i && (rd_e_i != '0);
  assign src_match  = (rs1_d_i == rd_e_i) || (rs2_used_d_i && (rs2_d_i == rd_e_i));
  assign load_use_o = load_in_ex && valid_d_i && reg_ren_d_i && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX register, 1-cycle latency; holds when valid_E && !ready_E, bubbles on load-use, flush wins.
// ID_EX_PERF_EN adds stall_cnt/flush_cnt performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_D,
  output logic               ready_D,
  input  logic [XLEN-1:0]    PC_reg_D,
  input  logic [XLEN-1:0]    rdata1_D,
  input  logic [XLEN-1:0]    rdata2_D,
  input  logic [XLEN-1:0]    imme_D,
  input  logic [REG_W-1:0]   Rs1_D,
  input  logic [REG_W-1:0]   Rs2_D,
  input  logic [REG_W-1:0]   Rd_D,
  input  logic               reg_ren_D,
  input  logic               rs2_used_D,
  input  logic               RegWrite_D,
  input  logic               MemRead_D,
  input  logic               MemWrite_D,
  input  logic               auipc_D,
  input  logic               ALU_DB_Src_D,
  input  logic [1:0]         ResultSrc_D,
  input  logic [2:0]         funct3_D,
  input  logic [ALUOP_W-1:0] ALUOp_D,
  input  logic               flush_E,
  input  logic               ready_E,
  output logic               valid_E,
  output logic [XLEN-1:0]    PC_reg_E,
  output logic [XLEN-1:0]    rdata1_E,
  output logic [XLEN-1:0]    rdata2_E,
  output logic [XLEN-1:0]    imme_E,
  output logic [REG_W-1:0]   Rs1_E,
  output logic [REG_W-1:0]   Rs2_E,
  output logic [REG_W-1:0]   Rd_E,
  output logic               reg_ren_E,
  output logic               rs2_used_E,
  output logic               RegWrite_E,
  output logic               MemRead_E,
  output logic               MemWrite_E,
  output logic               auipc_E,
  output logic               ALU_DB_Src_E,
  output logic [1:0]         ResultSrc_E,
  output logic [2:0]         funct3_E,
  output logic [ALUOP_W-1:0] ALUOp_E
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic         valid_q, valid_d;
  ctrl_t        ctrl_q, ctrl_d, ctrl_in;
  logic         advance, load_use, capture;

  logic [XLEN-1:0]    pc_q, rdata1_q, rdata2_q, imme_q;
  logic [REG_W-1:0]   rs1_q, rs2_q, rd_q;
  logic [2:0]         funct3_q;
  logic [ALUOP_W-1:0] aluop_q;

  hazard_load_use u_hazard (
    .valid_e_i    (valid_q),
    .memread_e_i  (ctrl_q.mem_read),
    .regwrite_e_i (ctrl_q.reg_write),
    .rd_e_i       (rd_q),
    .valid_d_i    (valid_D),
    .reg_ren_d_i  (reg_ren_D),
    .rs2_used_d_i (rs2_used_D),
    .rs1_d_i      (Rs1_D),
    .rs2_d_i      (Rs2_D),
    .load_use_o   (load_use)
  );

  assign advance = !valid_q || ready_E;
  assign ready_D = flush_E || (advance && !load_use);
  assign capture = !flush_E && advance && !load_use && valid_D;

  assign ctrl_in = '{reg_write:  RegWrite_D,
                     mem_read:   MemRead_D,
                     mem_write:  MemWrite_D,
                     auipc:      auipc_D,
                     alu_db_src: ALU_DB_Src_D,
                     result_src: ResultSrc_D,
                     reg_ren:    reg_ren_D,
                     rs2_used:   rs2_used_D};

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (flush_E) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (advance) begin
      if (capture) begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_in;
      end else begin
        // Bubble: strip side-effecting bits so forwarding never matches it.
        valid_d          = 1'b0;
        ctrl_d.reg_write = 1'b0;
        ctrl_d.mem_read  = 1'b0;
        ctrl_d.mem_write = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imme_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      aluop_q  <= '0;
    end else if (capture) begin
      pc_q     <= PC_reg_D;
      rdata1_q <= rdata1_D;
      rdata2_q <= rdata2_D;
      imme_q   <= imme_D;
      rs1_q    <= Rs1_D;
      rs2_q    <= Rs2_D;
      rd_q     <= Rd_D;
      funct3_q <= funct3_D;
      aluop_q  <= ALUOp_D;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use && !flush_E && advance) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_E && valid_q)              flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign valid_E      = valid_q;
  assign PC_reg_E     = pc_q;
  assign rdata1_E     = rdata1_q;
  assign rdata2_E     = rdata2_q;
  assign imme_E       = imme_q;
  assign Rs1_E        = rs1_q;
  assign Rs2_E        = rs2_q;
  assign Rd_E         = rd_q;
  assign funct3_E     = funct3_q;
  assign ALUOp_E      = aluop_q;
  assign reg_ren_E    = ctrl_q.reg_ren;
  assign rs2_used_E   = ctrl_q.rs2_used;
  assign RegWrite_E   = ctrl_q.reg_write;
  assign MemRead_E    = ctrl_q.mem_read;
  assign MemWrite_E   = ctrl_q.mem_write;
  assign auipc_E      = ctrl_q.auipc;
  assign ALU_DB_Src_E = ctrl_q.alu_db_src;
  assign ResultSrc_E  = ctrl_q.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage plus hand-written payload, hazard and counter sequences.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_D, ready_D;
  logic [31:0] PC_reg_D, rdata1_D, rdata2_D, imme_D;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic        reg_ren_D, rs2_used_D, RegWrite_D, MemRead_D, MemWrite_D, auipc_D, ALU_DB_Src_D;
  logic [1:0]  ResultSrc_D;
  logic [2:0]  funct3_D;
  logic [3:0]  ALUOp_D;
  logic        flush_E, ready_E, valid_E;
  logic [31:0] PC_reg_E, rdata1_E, rdata2_E, imme_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic        reg_ren_E, rs2_used_E, RegWrite_E, MemRead_E, MemWrite_E, auipc_E, ALU_DB_Src_E;
  logic [1:0]  ResultSrc_E;
  logic [2:0]  funct3_E;
  logic [3:0]  ALUOp_E;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_D(valid_D), .ready_D(ready_D),
    .PC_reg_D(PC_reg_D), .rdata1_D(rdata1_D), .rdata2_D(rdata2_D), .imme_D(imme_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .reg_ren_D(reg_ren_D), .rs2_used_D(rs2_used_D),
    .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D), .MemWrite_D(MemWrite_D), .auipc_D(auipc_D),
    .ALU_DB_Src_D(ALU_DB_Src_D), .ResultSrc_D(ResultSrc_D), .funct3_D(funct3_D), .ALUOp_D(ALUOp_D),
    .flush_E(flush_E), .ready_E(ready_E), .valid_E(valid_E),
    .PC_reg_E(PC_reg_E), .rdata1_E(rdata1_E), .rdata2_E(rdata2_E), .imme_E(imme_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .reg_ren_E(reg_ren_E), .rs2_used_E(rs2_used_E),
    .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .auipc_E(auipc_E),
    .ALU_DB_Src_E(ALU_DB_Src_E), .ResultSrc_E(ResultSrc_E), .funct3_E(funct3_E), .ALUOp_E(ALUOp_E)
`ifdef ID_EX_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        f_rst;
    logic        vD;
    logic        flush;
    logic        rdyE;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        ren, rs2u, rw, mr;
    logic        e_rdyD, e_vE, e_rw, e_mr, chk_pc;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t V(input logic f_rst, vD, flush, rdyE, input logic [31:0] pc,
                             input logic [4:0] rs1, rs2, rd, input logic ren, rs2u, rw, mr,
                             input logic e_rdyD, e_vE, e_rw, e_mr, chk_pc, input logic [31:0] e_pc);
    vec_t v;
    v.f_rst = f_rst; v.vD = vD; v.flush = flush; v.rdyE = rdyE; v.pc = pc;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ren = ren; v.rs2u = rs2u; v.rw = rw; v.mr = mr;
    v.e_rdyD = e_rdyD; v.e_vE = e_vE; v.e_rw = e_rw; v.e_mr = e_mr; v.chk_pc = chk_pc; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n        = v.f_rst;
    valid_D      = v.vD;
    flush_E      = v.flush;
    ready_E      = v.rdyE;
    PC_reg_D     = v.pc;
    rdata1_D     = v.pc ^ 32'h1111_1111;
    rdata2_D     = v.pc ^ 32'h2222_2222;
    imme_D       = {27'd0, v.rd};
    Rs1_D        = v.rs1;
    Rs2_D        = v.rs2;
    Rd_D         = v.rd;
    reg_ren_D    = v.ren;
    rs2_used_D   = v.rs2u;
    RegWrite_D   = v.rw;
    MemRead_D    = v.mr;
    MemWrite_D   = 1'b0;
    auipc_D      = 1'b0;
    ALU_DB_Src_D = 1'b0;
    ResultSrc_D  = v.mr ? 2'd1 : 2'd0;
    funct3_D     = 3'd2;
    ALUOp_D      = 4'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  initial begin
    //       rst vD fl rE  pc             rs1 rs2 rd  ren r2u rw mr | rdyD vE rw mr cpc e_pc
    vq.push_back(V(0, 1, 0, 1, 32'h0000_0100,  1,  2,  1, 1, 1, 1, 0,  1, 0, 0, 0, 1, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0000,  1,  2,  3, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0000));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0004,  1,  2,  4, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0004));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0008,  1,  2,  5, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0008));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_000C,  1,  0,  5, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_000C));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0010,  5,  1,  6, 1, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0010,  5,  1,  6, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0010));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0014,  6,  0,  0, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_0014));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0018,  0,  0,  7, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0018));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_001C,  2,  0,  9, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_001C));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0020,  3,  9, 10, 1, 0, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0020));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0024,  1,  0, 11, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_0024));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0028,  2, 11, 12, 1, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0028,  2, 11, 12, 1, 1, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0028));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_002C,  1,  0, 13, 1, 0, 1, 0,  1, 1, 1, 0, 1, 32'h8000_002C));
    for (int k = 0; k < 3; k++)
      vq.push_back(V(1, 1, 0, 0, 32'h8000_0030, 1, 0, 14, 1, 0, 1, 0, 0, 1, 1, 0, 1, 32'h8000_002C));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0030,  1,  0, 14, 1, 0, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0030));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0034,  1,  0, 15, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_0034));
    vq.push_back(V(1, 1, 1, 1, 32'h8000_0038, 15,  0, 16, 1, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_003C, 15,  0, 17, 1, 0, 1, 0,  1, 1, 1, 0, 1, 32'h8000_003C));
    vq.push_back(V(1, 0, 1, 1, 32'h8000_0040,  0,  0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0));
    vq.push_back(V(1, 0, 0, 1, 32'h8000_0040,  0,  0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0040,  1,  0, 18, 1, 0, 1, 1,  1, 1, 1, 1, 1, 32'h8000_0040));
    vq.push_back(V(0, 1, 0, 0, 32'h8000_0044,  1,  0, 19, 1, 0, 1, 0,  0, 0, 0, 0, 1, 32'h0));
    vq.push_back(V(1, 1, 0, 1, 32'h8000_0048,  1,  0, 20, 1, 0, 1, 0,  1, 1, 1, 0, 1, 32'h8000_0048));

    apply(V(0, 1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      apply(vq[i]);
      #1;
      chk($sformatf("step%0d ready_D", i), {31'd0, ready_D}, {31'd0, vq[i].e_rdyD});
      @(posedge clk);
      #1;
      chk($sformatf("step%0d valid_E", i), {31'd0, valid_E}, {31'd0, vq[i].e_vE});
      chk($sformatf("step%0d RegWrite_E", i), {31'd0, RegWrite_E}, {31'd0, vq[i].e_rw});
      chk($sformatf("step%0d MemRead_E", i), {31'd0, MemRead_E}, {31'd0, vq[i].e_mr});
      chk($sformatf("step%0d MemWrite_E", i), {31'd0, MemWrite_E}, 32'd0);
      if (vq[i].chk_pc) chk($sformatf("step%0d PC_reg_E", i), PC_reg_E, vq[i].e_pc);
    end

    // Full payload pass-through with distinct values in every field.
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'hDEAD_BEE0, 7, 8, 9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    rdata1_D = 32'h1234_5678; rdata2_D = 32'h9ABC_DEF0; imme_D = 32'hFFFF_F800;
    MemWrite_D = 1'b1; auipc_D = 1'b1; ALU_DB_Src_D = 1'b1; ResultSrc_D = 2'd2;
    funct3_D = 3'd5; ALUOp_D = 4'hB;
    #1;
    chk("payload ready_D", {31'd0, ready_D}, 32'd1);
    @(posedge clk);
    #1;
    chk("payload PC_reg_E", PC_reg_E, 32'hDEAD_BEE0);
    chk("payload rdata1_E", rdata1_E, 32'h1234_5678);
    chk("payload rdata2_E", rdata2_E, 32'h9ABC_DEF0);
    chk("payload imme_E", imme_E, 32'hFFFF_F800);
    chk("payload Rs1_E", {27'd0, Rs1_E}, 32'd7);
    chk("payload Rs2_E", {27'd0, Rs2_E}, 32'd8);
    chk("payload Rd_E", {27'd0, Rd_E}, 32'd9);
    chk("payload reg_ren_E", {31'd0, reg_ren_E}, 32'd1);
    chk("payload rs2_used_E", {31'd0, rs2_used_E}, 32'd0);
    chk("payload MemWrite_E", {31'd0, MemWrite_E}, 32'd1);
    chk("payload auipc_E", {31'd0, auipc_E}, 32'd1);
    chk("payload ALU_DB_Src_E", {31'd0, ALU_DB_Src_E}, 32'd1);
    chk("payload ResultSrc_E", {30'd0, ResultSrc_E}, 32'd2);
    chk("payload funct3_E", {29'd0, funct3_E}, 32'd5);
    chk("payload ALUOp_E", {28'd0, ALUOp_E}, 32'hB);

    // Load in EX, dependant in ID that does not read registers: no stall.
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'h0000_0050, 1, 0, 20, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'h0000_0054, 20, 20, 21, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    #1;
    chk("noren ready_D", {31'd0, ready_D}, 32'd1);
    @(posedge clk);
    #1;
    chk("noren valid_E", {31'd0, valid_E}, 32'd1);
    chk("noren PC_reg_E", PC_reg_E, 32'h0000_0054);

`ifdef ID_EX_PERF_EN
    @(negedge clk);
    apply(V(0, 1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("perf reset stall_cnt", stall_cnt, 32'd0);
    chk("perf reset flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'h100, 1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'h104, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("perf stall_cnt after stall", stall_cnt, 32'd1);
    @(negedge clk);
    @(negedge clk);
    apply(V(1, 1, 0, 1, 32'h108, 1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    apply(V(1, 1, 1, 1, 32'h10C, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("perf flush valid_E", {31'd0, valid_E}, 32'd0);
    chk("perf flush RegWrite_E", {31'd0, RegWrite_E}, 32'd0);
    chk("perf stall_cnt after flush", stall_cnt, 32'd1);
    chk("perf flush_cnt after flush", flush_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
